record_step_sequencer: RTL
==========================

# record_step_sequencer

Controller that drains motion records from the SPI-fed record FIFO and turns each one into step/direction pulse trains on the four motor channels (p1..p8). It owns the FIFO read side: it fetches one 2-word record, applies the direction bits, emits the requested number of step pulses at a programmable period, then fetches the next record. It sits between the FIFO's `read_en`/`data_out` and the top-level pin outputs; the SPI command FSM owns the write side.

## Interface
- `WORD_SIZE`, 8: FIFO word width; record word layout below assumes 8.
- `PULSE_CYCLES`, 4: step high time in clk cycles, ≥1.
- `SETUP_CYCLES`, 2: dir-to-first-step setup time in clk cycles, ≥1.
- `clk`  in  1  sole clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  permits fetching new records; sampled in IDLE only.
- `step_period`  in  16  clk cycles between step rising edges; latched at record capture.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  WORD_SIZE  FIFO `data_out`; valid the cycle after `fifo_read_en`.
- `fifo_read_en`  out  1  pops one word; combinational from state and `fifo_empty`.
- `step`  out  4  step pulses, one bit per axis.
- `dir`  out  4  direction levels, one bit per axis.
- `busy`  out  1  high in every state except IDLE.
- `record_done`  out  1  one-cycle pulse when a record completes.
- `steps_left`  out  8  remaining steps of the current record.

## Operation
- Record format: word0 = {dir[3:0], mask[3:0]}, word1 = step count N (0..255).
- States: IDLE, RD0, CAP0, RD1, CAP1, SETUP, HIGH, LOW, DONE.
- IDLE: if `enable` and not `fifo_empty`, go to RD0. Otherwise stay.
- RD0: `fifo_read_en`=1, then go to CAP0.
- CAP0: capture `fifo_data` into mask/dir-shadow registers, then go to RD1.
- RD1: `fifo_read_en` = !`fifo_empty`. If the FIFO is not empty, go to CAP1; otherwise stay (partial record; wait indefinitely).
- CAP1: capture N into the count register and `steps_left`. Drive `dir` from the shadow. Latch the effective period P = max(`step_period`, 2*`PULSE_CYCLES`). If N=0, go to DONE; otherwise go to SETUP.
- SETUP: hold for `SETUP_CYCLES` cycles, then go to HIGH.
- HIGH: `step` = mask for `PULSE_CYCLES` cycles. On exit, decrement `steps_left`, then go to LOW.
- LOW: `step`=0 for P−`PULSE_CYCLES` cycles. Then go to HIGH if `steps_left`≠0, else go to DONE.
- DONE: `record_done`=1 for one cycle, then go to IDLE.
- `dir` holds its last value between records. A mask of 0 still runs the full timing with no visible pulses.
- `enable` deassertion mid-record has no effect. The current record completes and no new fetch starts.
- `step_period` changes mid-record are ignored until the next CAP1.
- Counters: the phase timer is 16-bit and never wraps because P ≤ 65535. `steps_left` never underflows because decrement happens only from N≥1.

## Timing
- Reset values: state IDLE, `step`=0, `dir`=0, `busy`=0, `record_done`=0, `steps_left`=0, `fifo_read_en`=0.
- Reset mid-record: on the next edge all outputs return to reset values. The partially consumed record is discarded; the FIFO is not rewound.
- Fetch latency: the cycle with IDLE and the condition true is cycle t. Then RD0 at t+1, CAP0 at t+2, RD1 at t+3, CAP1 at t+4. `dir` is valid from t+5.
- First `step` rising edge occurs at t+5+`SETUP_CYCLES`.
- Step rising edges are exactly P cycles apart. High time is exactly `PULSE_CYCLES`.
- `record_done` is asserted P−`PULSE_CYCLES` cycles after the last falling edge. For N=0 it is asserted the cycle after CAP1.
- Back-to-back records: DONE and IDLE each take one cycle, so a queued record's RD0 begins 2 cycles after DONE.
- `fifo_read_en` is never asserted while `fifo_empty`=1 and never more than 2 times per record.

## Test plan
- Single record, word0=0x31, N=3, `step_period`=10, PULSE=4, SETUP=2. Required: `dir`=0x3 from t+5; three pulses on `step[0]` only, at t+7, t+17, t+27, each 4 cycles high; `record_done` at t+37; `steps_left` goes 3→2→1→0.
- N=0 record with word0=0xA5. Required: no `step` activity, `dir`=0xA, `record_done` at t+5, `busy` falls at t+6.
- `step_period`=3 with PULSE=4. Required: rising edges spaced 8 cycles, high time 4.
- Write word0 only, then hold FIFO empty for 20 cycles, then write word1. Required: stall in RD1 with `fifo_read_en`=0 and `busy`=1; CAP1 one cycle after word1 is visible.
- Two queued records, then drop `enable` during the first record's HIGH phase. Required: the first record completes with all pulses, the second is not fetched, `busy`=0, and FIFO size stays at 2 words.
- Assert `rst` during LOW of step 2 of 5. Required: next cycle `step`=0, `dir`=0, `steps_left`=0, state IDLE; with `enable`=1 the next fetch reads the following FIFO word.

Source files
------------

// File: rtl/record_step_sequencer.sv
// Drains 2-word motion records from the record FIFO and turns each into
// direction levels plus a train of step pulses with programmable period.
module record_step_sequencer #(
  parameter int WORD_SIZE    = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int SETUP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [15:0]          step_period,
  input  logic                 fifo_empty,
  input  logic [WORD_SIZE-1:0] fifo_data,
  output logic                 fifo_read_en,
  output logic [3:0]           step,
  output logic [3:0]           dir,
  output logic                 busy,
  output logic                 record_done,
  output logic [7:0]           steps_left
);

  typedef enum logic [3:0] {
    IDLE,
    RD0,
    CAP0,
    RD1,
    CAP1,
    SETUP,
    HIGH,
    LOW,
    DONE
  } state_t;

  localparam logic [15:0] MIN_PERIOD = 16'(2 * PULSE_CYCLES);
  localparam logic [15:0] PULSE_LEN  = 16'(PULSE_CYCLES);
  localparam logic [15:0] HIGH_LOAD  = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] SETUP_LOAD = 16'(SETUP_CYCLES - 1);

  state_t      state;
  logic [15:0] timer;
  logic [15:0] period;
  logic [3:0]  mask;
  logic [3:0]  dir_shadow;

  // The RD1 read is gated so a partial record stalls without popping an empty FIFO.
  assign fifo_read_en = (state == RD0) || ((state == RD1) && !fifo_empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      period      <= '0;
      mask        <= '0;
      dir_shadow  <= '0;
      step        <= '0;
      dir         <= '0;
      busy        <= 1'b0;
      record_done <= 1'b0;
      steps_left  <= '0;
    end else begin
      record_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !fifo_empty) begin
            state <= RD0;
            busy  <= 1'b1;
          end
        end
        RD0: state <= CAP0;
        CAP0: begin
          mask       <= fifo_data[3:0];
          dir_shadow <= fifo_data[7:4];
          state      <= RD1;
        end
        RD1: begin
          if (!fifo_empty) state <= CAP1;
        end
        CAP1: begin
          steps_left <= fifo_data[7:0];
          dir        <= dir_shadow;
          period     <= (step_period < MIN_PERIOD) ? MIN_PERIOD : step_period;
          timer      <= SETUP_LOAD;
          if (fifo_data[7:0] == 8'd0) begin
            state       <= DONE;
            record_done <= 1'b1;
          end else begin
            state <= SETUP;
          end
        end
        SETUP: begin
          if (timer == 16'd0) begin
            state <= HIGH;
            step  <= mask;
            timer <= HIGH_LOAD;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        HIGH: begin
          if (timer == 16'd0) begin
            state      <= LOW;
            step       <= '0;
            steps_left <= steps_left - 8'd1;
            timer      <= period - PULSE_LEN - 16'd1;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        // Period is at least twice the pulse width, so the LOW load never underflows.
        LOW: begin
          if (timer == 16'd0) begin
            if (steps_left != 8'd0) begin
              state <= HIGH;
              step  <= mask;
              timer <= HIGH_LOAD;
            end else begin
              state       <= DONE;
              record_done <= 1'b1;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
